// File: rtl/ser2par_bus.sv
// rtl/ser2par_bus.sv - serial-to-parallel word capture with one-entry valid/ready output register
// Optional build macro: SER2PAR_PARITY_EN (adds a trailing even-parity bit per word)
module ser2par_bus #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             d_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] out_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SER2PAR_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] started;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             perr;
  logic             last_data;

  // First serial bit ends up at the far end of the word after WIDTH shifts.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sreg[WIDTH-2:0], d_in};
      started = {{(WIDTH-1){1'b0}}, d_in};
    end else begin
      shifted = {d_in, sreg[WIDTH-1:1]};
      started = {d_in, {(WIDTH-1){1'b0}}};
    end
  end

  assign last_data = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  always_comb begin
    done = 1'b0;
    word = shifted;
    perr = 1'b0;
    if (d_valid && !frame) begin
`ifdef SER2PAR_PARITY_EN
      if (state == PARITY) begin
        done = 1'b1;
        word = sreg;
        perr = (^sreg) ^ d_in;
      end
`else
      if (last_data) done = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      out_bus    <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (d_valid) begin
        if (frame) begin
          sreg  <= started;
          cnt   <= CW'(1);
          state <= SHIFT;
        end else begin
          case (state)
            SHIFT: begin
              sreg <= shifted;
              if (last_data) begin
                cnt <= '0;
`ifdef SER2PAR_PARITY_EN
                state <= PARITY;
`else
                state <= IDLE;
`endif
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
`ifdef SER2PAR_PARITY_EN
            PARITY: state <= IDLE;
`endif
            default: ;
          endcase
        end
      end

      // A completing word may replace one being drained on the same edge.
      if (done) begin
        if (!out_valid || out_ready) begin
          out_bus    <= word;
          out_valid  <= 1'b1;
          parity_err <= perr;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ser2par_bus.sv
// tb/tb_ser2par_bus.sv - vector table, corner sequences and random stimulus against a bit-queue model
module tb_ser2par_bus;

`ifdef SER2PAR_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_in = 1'b0;
  logic       d_valid = 1'b0;
  logic       frame = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_bus, out_bus_l;
  logic       out_valid, out_valid_l;
  logic       overrun, overrun_l;
  logic       parity_err, parity_err_l;

  ser2par_bus #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .frame(frame),
    .out_bus(out_bus), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .parity_err(parity_err)
  );

  ser2par_bus #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .frame(frame),
    .out_bus(out_bus_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .overrun(overrun_l), .parity_err(parity_err_l)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  bit         partial[$];
  logic       m_valid = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
  logic [7:0] m_bus = 8'h00, m_bus_l = 8'h00;

  typedef struct {
    logic [7:0] word;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_bus;
    logic       exp_ovr;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word is the list of bits seen since the last frame; it completes at NB bits.
  task automatic model_edge(input logic d, input logic v, input logic f);
    logic       done;
    logic [7:0] wm, wl;
    logic       p;
    done = 1'b0; wm = '0; wl = '0; p = 1'b0;
    if (rst) begin
      partial.delete();
      m_valid = 0; m_bus = 0; m_bus_l = 0; m_ovr = 0; m_perr = 0;
      return;
    end
    if (v) begin
      if (f) begin
        partial.delete();
        partial.push_back(d);
      end else if (partial.size() > 0) begin
        partial.push_back(d);
        if (partial.size() == NB) begin
          done = 1'b1;
          for (int k = 0; k < 8; k++) begin
            wm[7-k] = partial[k];
            wl[k]   = partial[k];
          end
`ifdef SER2PAR_PARITY_EN
          for (int k = 0; k < NB; k++) p = p ^ partial[k];
`endif
          partial.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_valid = 1; m_bus = wm; m_bus_l = wl; m_perr = p;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_valid);
    chk("out_bus", out_bus, m_bus);
    chk("overrun", overrun, m_ovr);
    chk("parity_err", parity_err, m_perr);
    chk("lsb_out_valid", out_valid_l, m_valid);
    chk("lsb_out_bus", out_bus_l, m_bus_l);
  endtask

  task automatic step(input logic d, input logic v, input logic f);
    d_in = d; d_valid = v; frame = f;
    if (out_valid && out_ready && !rst) xfers++;
    model_edge(d, v, f);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic flip);
    for (int k = 0; k < 8; k++) step(w[7-k], 1'b1, k == 0);
`ifdef SER2PAR_PARITY_EN
    step((^w) ^ flip, 1'b1, 1'b0);
`endif
  endtask

  initial begin
    int x0;
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0};
    tbl[2] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0};
    tbl[3] = '{8'h11, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[4] = '{8'h22, 1'b0, 1'b1, 8'h11, 1'b1};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_bus", out_bus, 8'h00);
      chk("idle_ovr", overrun, 1'b0);
    end

    x0 = xfers;
    for (int i = 0; i < 5; i++) begin
      out_ready = tbl[i].rdy;
      send_word(tbl[i].word, 1'b0);
      chk("tbl_valid", out_valid, tbl[i].exp_valid);
      chk("tbl_bus", out_bus, tbl[i].exp_bus);
      chk("tbl_ovr", overrun, tbl[i].exp_ovr);
      if (i == 2) begin
        step(1'b0, 1'b0, 1'b0);
        chk("three_xfers", xfers - x0, 3);
      end
    end
    out_ready = 1'b1;
    x0 = xfers;
    step(1'b0, 1'b0, 1'b0);
    chk("drain_xfers", xfers - x0, 1);
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_bus", out_bus, 8'h11);
    chk("drain_ovr_sticky", overrun, 1'b1);

    // Completion and drain on the same edge: no bubble.
    do_reset();
    out_ready = 1'b0;
    send_word(8'h3C, 1'b0);
    x0 = xfers;
    for (int k = 0; k < NB; k++) begin
      out_ready = (k == NB - 1);
      if (k < 8) step(8'hC3 >> (7 - k), 1'b1, k == 0);
      else step(^8'hC3, 1'b1, 1'b0);
      chk("nobubble_valid", out_valid, 1'b1);
    end
    chk("nobubble_bus", out_bus, 8'hC3);
    chk("nobubble_xfer", xfers - x0, 1);
    chk("nobubble_ovr", overrun, 1'b0);

    // Frame mid-word restarts capture.
    do_reset();
    out_ready = 1'b1;
    x0 = xfers;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    send_word(8'h0F, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("restart_xfers", xfers - x0, 1);
    chk("restart_bus", out_bus, 8'h0F);

    // Reset mid-word loses the partial word.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, k == 0);
    do_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_bus", out_bus, 8'h00);
    chk("rst_ovr", overrun, 1'b0);
    x0 = xfers;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_noword", xfers - x0, 0);
    chk("rst_valid_after", out_valid, 1'b0);

`ifdef SER2PAR_PARITY_EN
    do_reset();
    out_ready = 1'b1;
    send_word(8'h01, 1'b1);
    chk("par_bad", parity_err, 1'b1);
    send_word(8'h01, 1'b0);
    chk("par_good", parity_err, 1'b0);
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
